// File: rtl/peak_interval_detector.sv
// Hysteresis peak/trough detector with refractory window, beat interval and stale timeout.
// Optional PEAK_AMPLITUDE_EN adds peak_amp (last max minus trough min, loaded on each trough).
module peak_interval_detector #(
    parameter int DATA_W  = 10,
    parameter int CNT_W   = 16,
    parameter int HYST    = 8,
    parameter int REFRACT = 50,
    parameter int TIMEOUT = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              peak_pulse,
    output logic              trough_pulse,
    output logic [CNT_W-1:0]  num_peaks,
    output logic [CNT_W-1:0]  num_troughs,
    output logic [CNT_W-1:0]  interval,
    output logic              interval_valid,
    output logic              stale
`ifdef PEAK_AMPLITUDE_EN
    ,
    output logic [DATA_W-1:0] peak_amp
`endif
);

    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;
    localparam logic [DATA_W:0] HYST_X = (DATA_W + 1)'(HYST);

    typedef enum logic [1:0] {INIT, RISING, FALLING} state_t;

    state_t            state_q, state_nx;
    logic [DATA_W-1:0] max_q, max_nx, min_q, min_nx;
    logic [RW-1:0]     refr_q, refr_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              has_prev_q, has_prev_nx;
    logic              peak_nx, trough_nx, ival_nx, stale_nx;
    logic [CNT_W-1:0]  npk_nx, ntr_nx, interval_nx;
    logic              drop, rise, accept;
`ifdef PEAK_AMPLITUDE_EN
    logic [DATA_W-1:0] amp_nx;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Extended-width compares so sample+HYST and min+HYST never wrap
    assign drop = ({1'b0, sample} + HYST_X) <= {1'b0, max_q};
    assign rise = {1'b0, sample} >= ({1'b0, min_q} + HYST_X);

    always_comb begin
        state_nx    = state_q;
        max_nx      = max_q;
        min_nx      = min_q;
        refr_nx     = refr_q;
        cnt_nx      = cnt_q;
        has_prev_nx = has_prev_q;
        stale_nx    = stale;
        npk_nx      = num_peaks;
        ntr_nx      = num_troughs;
        interval_nx = interval;
        peak_nx     = 1'b0;
        trough_nx   = 1'b0;
        ival_nx     = 1'b0;
        accept      = 1'b0;
`ifdef PEAK_AMPLITUDE_EN
        amp_nx      = peak_amp;
`endif
        if (sample_valid) begin
            refr_nx = (refr_q != '0) ? refr_q - RW'(1) : '0;
            cnt_nx  = sat_inc(cnt_q);
            case (state_q)
                INIT: begin
                    max_nx   = sample;
                    min_nx   = sample;
                    state_nx = RISING;
                end
                RISING: begin
                    if (sample > max_q) begin
                        max_nx = sample;
                    end else if (drop) begin
                        state_nx = FALLING;
                        min_nx   = sample;
                        accept   = (refr_q == '0);
                    end
                end
                FALLING: begin
                    if (sample < min_q) begin
                        min_nx = sample;
                    end else if (rise) begin
                        trough_nx = 1'b1;
                        ntr_nx    = sat_inc(num_troughs);
                        max_nx    = sample;
                        state_nx  = RISING;
`ifdef PEAK_AMPLITUDE_EN
                        amp_nx    = max_q - min_q;
`endif
                    end
                end
                default: state_nx = INIT;
            endcase

            // A peak after a stale period restarts interval measurement
            if (accept) begin
                peak_nx     = 1'b1;
                npk_nx      = sat_inc(num_peaks);
                refr_nx     = RW'(REFRACT);
                cnt_nx      = '0;
                has_prev_nx = 1'b1;
                stale_nx    = 1'b0;
                if (has_prev_q && !stale) begin
                    interval_nx = sat_inc(cnt_q);
                    ival_nx     = 1'b1;
                end
            end else if (has_prev_q && cnt_nx == CNT_W'(TIMEOUT)) begin
                stale_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= INIT;
            max_q          <= '0;
            min_q          <= '0;
            refr_q         <= '0;
            cnt_q          <= '0;
            has_prev_q     <= 1'b0;
            peak_pulse     <= 1'b0;
            trough_pulse   <= 1'b0;
            num_peaks      <= '0;
            num_troughs    <= '0;
            interval       <= '0;
            interval_valid <= 1'b0;
            stale          <= 1'b0;
`ifdef PEAK_AMPLITUDE_EN
            peak_amp       <= '0;
`endif
        end else begin
            state_q        <= state_nx;
            max_q          <= max_nx;
            min_q          <= min_nx;
            refr_q         <= refr_nx;
            cnt_q          <= cnt_nx;
            has_prev_q     <= has_prev_nx;
            peak_pulse     <= peak_nx;
            trough_pulse   <= trough_nx;
            num_peaks      <= npk_nx;
            num_troughs    <= ntr_nx;
            interval       <= interval_nx;
            interval_valid <= ival_nx;
            stale          <= stale_nx;
`ifdef PEAK_AMPLITUDE_EN
            peak_amp       <= amp_nx;
`endif
        end
    end

endmodule
